multi_alarm_clock: RTL and testbench
====================================

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameters (name, default, meaning): TICK_DIV, 1, clk cycles per second; NUM_ALARMS, 4, alarm slots; NUM_TIMERS, 2, countdown channels; RING_SEC, 10, alarm auto-silence in seconds. AW = max(1,clog2(NUM_ALARMS)), TW = max(1,clog2(NUM_TIMERS)).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  reset is asynchronous and active-low.
REQ-004 set_valid  in  1  load time/date this cycle; set_hour in 5, set_min in 6, set_sec in 6, set_day in 5, set_month in 4, set_year in 12.
REQ-005 alarm_wr  in  1  write slot alarm_idx (in AW) with alarm_hour in 5, alarm_min in 6, alarm_sec in 6, alarm_en in 1.
REQ-006 alarm_ack  in  NUM_ALARMS  per-slot dismiss.
REQ-007 timer_load  in  1  load channel timer_idx (in TW) with timer_min in 6, timer_sec in 6; timer_cancel in NUM_TIMERS per-channel abort.
REQ-008 mon_idx  in  TW  channel shown on timer_count_min/timer_count_sec (out, 6 each).
REQ-009 hour out 5, min out 6, sec out 6, day out 5, month out 4, year out 12, sec_pulse out 1 (one-cycle second strobe).
REQ-010 alarm_buzzer out NUM_ALARMS; timer_buzzer out NUM_TIMERS; timer_busy out NUM_TIMERS.

Function
REQ-011 Prescaler SHALL count 0..TICK_DIV-1; sec_pulse=1 for exactly the cycle it equals TICK_DIV-1; TICK_DIV=1 gives sec_pulse every cycle.
REQ-012 On sec_pulse, time SHALL advance one second: sec 59->0 carries min, min 59->0 carries hour, hour 23->0 carries day; all outputs registered, updated on that edge.
REQ-013 Day rollover SHALL use month length 31/30/28-29; leap = year%4==0 and (year%100!=0 or year%400==0); month 12->1 increments year; year 4095 wraps to 0.
REQ-014 set_valid SHALL load all six fields next edge and clear the prescaler, taking priority over a coincident sec_pulse; if any field is out of range (hour>23, min/sec>59, month 0 or >12, day 0 or > month length for set_year) the whole request SHALL be ignored.
REQ-015 Alarm slot k SHALL fire when enabled and the time value produced by a sec_pulse advance equals its stored h:m:s; alarm_buzzer[k] rises on the same edge as the matching time; a set_valid load SHALL NOT fire alarms.
REQ-016 Firing SHALL clear slot k's enable (one-shot); buzzer stays high until alarm_ack[k] (cleared next edge) or RING_SEC sec_pulses elapse, whichever first.
REQ-017 Multiple slots matching the same second SHALL all fire; alarm_wr to a ringing slot SHALL silence it and store the new setting; out-of-range alarm values SHALL be ignored.
REQ-018 timer_load with count 00:00 or timer_sec>59 SHALL be ignored; otherwise channel loads, timer_busy=1, timer_buzzer cleared; loading a busy channel restarts it.
REQ-019 Each busy channel SHALL decrement on sec_pulse (sec 0, min>0 -> min-1, sec 59); transition to 00:00 SHALL clear busy and set timer_buzzer for exactly one second (until next sec_pulse).
REQ-020 Coincident timer_load and sec_pulse on same channel: load wins, no decrement that cycle; timer_cancel clears busy, buzzer and count to 0 next edge, priority over load.
REQ-021 timer_count_min/sec SHALL combinationally show channel mon_idx; mon_idx >= NUM_TIMERS SHALL show 0.

Reset
REQ-022 reset low SHALL immediately force: time 00:00:00, date 01-01-2020, prescaler 0, sec_pulse 0, all alarm slots 00:00:00 disabled, all buzzers 0, all timers idle with count 0; mid-ringing or mid-countdown state is discarded.

Verification
REQ-023 Set 23:59:58 31-12-2023, 3 pulses -> 00:00:01 01-01-2024.
REQ-024 Set 23:59:59 28-02-2100 then 1 pulse -> 01-03-2100; same with 2000 -> 29-02-2000; set_day 30 month 2 -> ignored, time unchanged.
REQ-025 Slots 0 and 2 both at 00:00:05, time 00:00:00 -> both buzzers rise with sec=5; ack[0] at sec 7 drops slot 0; slot 2 drops after 10 pulses (sec 15); neither refires next day.
REQ-026 Load ch0 00:03, ch1 01:00 -> ch0 buzzer at third pulse for one second; ch1 shows 00:59 after first pulse; cancel ch1 mid-count -> busy 0, count 00:00.
REQ-027 TICK_DIV=4: sec_pulse every 4th cycle; set_valid on pulse cycle -> loaded value held, next pulse 4 cycles later.
REQ-028 Assert reset during ringing alarm and busy timer -> all buzzers and busy 0 without clock edge; time 00:00:00 01-01-2020.

Source files
------------

// File: rtl/multi_alarm_clock.sv
// Real-time clock/calendar with one-shot alarm slots and countdown timer channels.
// One internal tick per second, derived from a prescaler on clk_i.
module multi_alarm_clock #(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned NUM_TIMERS = 2,
  parameter int unsigned RING_SEC   = 10,
  localparam int unsigned AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int unsigned TW = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_valid_i,
  input  logic [4:0]            set_hour_i,
  input  logic [5:0]            set_min_i,
  input  logic [5:0]            set_sec_i,
  input  logic [4:0]            set_day_i,
  input  logic [3:0]            set_month_i,
  input  logic [11:0]           set_year_i,
  input  logic                  alarm_wr_i,
  input  logic [AW-1:0]         alarm_idx_i,
  input  logic [4:0]            alarm_hour_i,
  input  logic [5:0]            alarm_min_i,
  input  logic [5:0]            alarm_sec_i,
  input  logic                  alarm_en_i,
  input  logic [NUM_ALARMS-1:0] alarm_ack_i,
  input  logic                  timer_load_i,
  input  logic [TW-1:0]         timer_idx_i,
  input  logic [5:0]            timer_min_i,
  input  logic [5:0]            timer_sec_i,
  input  logic [NUM_TIMERS-1:0] timer_cancel_i,
  input  logic [TW-1:0]         mon_idx_i,
  output logic [5:0]            timer_count_min_o,
  output logic [5:0]            timer_count_sec_o,
  output logic [4:0]            hour_o,
  output logic [5:0]            min_o,
  output logic [5:0]            sec_o,
  output logic [4:0]            day_o,
  output logic [3:0]            month_o,
  output logic [11:0]           year_o,
  output logic                  sec_pulse_o,
  output logic [NUM_ALARMS-1:0] alarm_buzzer_o,
  output logic [NUM_TIMERS-1:0] timer_buzzer_o,
  output logic [NUM_TIMERS-1:0] timer_busy_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RingMax  = RW'(RING_SEC - 1);

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [11:0] y);
    logic leap;
    leap = (y[1:0] == 2'd0) && ((y % 12'd100 != 12'd0) || (y % 12'd400 == 12'd0));
    case (m)
      4'd2:                      return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic          pulse_q, pulse_d;
  logic [4:0]    hour_q, hour_d, day_q, day_d, adv_hour, adv_day;
  logic [5:0]    min_q, min_d, sec_q, sec_d, adv_min, adv_sec;
  logic [3:0]    month_q, month_d, adv_month;
  logic [11:0]   year_q, year_d, adv_year;
  logic          set_ok, alarm_ok, load_ok, tick;

  logic [4:0]            al_hour_q [NUM_ALARMS];
  logic [4:0]            al_hour_d [NUM_ALARMS];
  logic [5:0]            al_min_q  [NUM_ALARMS];
  logic [5:0]            al_min_d  [NUM_ALARMS];
  logic [5:0]            al_sec_q  [NUM_ALARMS];
  logic [5:0]            al_sec_d  [NUM_ALARMS];
  logic [RW-1:0]         ring_cnt_q [NUM_ALARMS];
  logic [RW-1:0]         ring_cnt_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] al_en_q, al_en_d, ring_q, ring_d;

  logic [5:0]            tm_min_q [NUM_TIMERS];
  logic [5:0]            tm_min_d [NUM_TIMERS];
  logic [5:0]            tm_sec_q [NUM_TIMERS];
  logic [5:0]            tm_sec_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] busy_q, busy_d, tbuzz_q, tbuzz_d;

  // The second strobe is registered so it reads 0 straight out of reset.
  assign tick = pulse_q;

  assign set_ok = set_valid_i && (set_hour_i <= 5'd23) && (set_min_i <= 6'd59) &&
                  (set_sec_i <= 6'd59) && (set_month_i != 4'd0) && (set_month_i <= 4'd12) &&
                  (set_day_i != 5'd0) && (set_day_i <= month_len(set_month_i, set_year_i));
  assign alarm_ok = alarm_wr_i && (alarm_hour_i <= 5'd23) && (alarm_min_i <= 6'd59) &&
                    (alarm_sec_i <= 6'd59);
  assign load_ok  = timer_load_i && (timer_sec_i <= 6'd59) &&
                    ((timer_min_i != 6'd0) || (timer_sec_i != 6'd0));

  // Prescaler and calendar advance with carry chain.
  always_comb begin
    presc_d = (set_ok || presc_q == PrescMax) ? '0 : presc_q + PW'(1);
    pulse_d = (presc_d == PrescMax);
    adv_sec = sec_q + 6'd1;
    adv_min = min_q;
    adv_hour = hour_q;
    adv_day = day_q;
    adv_month = month_q;
    adv_year = year_q;
    if (sec_q == 6'd59) begin
      adv_sec = 6'd0;
      adv_min = min_q + 6'd1;
      if (min_q == 6'd59) begin
        adv_min  = 6'd0;
        adv_hour = hour_q + 5'd1;
        if (hour_q == 5'd23) begin
          adv_hour = 5'd0;
          adv_day  = day_q + 5'd1;
          if (day_q >= month_len(month_q, year_q)) begin
            adv_day   = 5'd1;
            adv_month = month_q + 4'd1;
            if (month_q == 4'd12) begin
              adv_month = 4'd1;
              adv_year  = year_q + 12'd1;
            end
          end
        end
      end
    end
    {hour_d, min_d, sec_d, day_d, month_d, year_d} = {hour_q, min_q, sec_q, day_q, month_q, year_q};
    if (set_ok) begin
      {hour_d, min_d, sec_d, day_d, month_d, year_d} =
          {set_hour_i, set_min_i, set_sec_i, set_day_i, set_month_i, set_year_i};
    end else if (tick) begin
      {hour_d, min_d, sec_d, day_d, month_d, year_d} =
          {adv_hour, adv_min, adv_sec, adv_day, adv_month, adv_year};
    end
  end

  // Alarm slots: write, one-shot fire on advanced time, ring until ack or timeout.
  always_comb begin
    al_hour_d = al_hour_q;
    al_min_d = al_min_q;
    al_sec_d = al_sec_q;
    ring_cnt_d = ring_cnt_q;
    al_en_d = al_en_q;
    ring_d = ring_q;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (alarm_ok && alarm_idx_i == AW'(k)) begin
        al_hour_d[k] = alarm_hour_i;
        al_min_d[k] = alarm_min_i;
        al_sec_d[k] = alarm_sec_i;
        al_en_d[k] = alarm_en_i;
        ring_d[k] = 1'b0;
        ring_cnt_d[k] = '0;
      end else if (tick && !set_ok && al_en_q[k] && adv_hour == al_hour_q[k] &&
                   adv_min == al_min_q[k] && adv_sec == al_sec_q[k]) begin
        al_en_d[k] = 1'b0;
        ring_d[k] = 1'b1;
        ring_cnt_d[k] = '0;
      end else if (ring_q[k]) begin
        if (alarm_ack_i[k]) begin
          ring_d[k] = 1'b0;
        end else if (tick) begin
          if (ring_cnt_q[k] == RingMax) ring_d[k] = 1'b0;
          else ring_cnt_d[k] = ring_cnt_q[k] + RW'(1);
        end
      end
    end
  end

  // Countdown channels: cancel beats load, load beats decrement.
  always_comb begin
    tm_min_d = tm_min_q;
    tm_sec_d = tm_sec_q;
    busy_d = busy_q;
    tbuzz_d = tbuzz_q;
    for (int j = 0; j < NUM_TIMERS; j++) begin
      if (timer_cancel_i[j]) begin
        tm_min_d[j] = 6'd0;
        tm_sec_d[j] = 6'd0;
        busy_d[j] = 1'b0;
        tbuzz_d[j] = 1'b0;
      end else if (load_ok && timer_idx_i == TW'(j)) begin
        tm_min_d[j] = timer_min_i;
        tm_sec_d[j] = timer_sec_i;
        busy_d[j] = 1'b1;
        tbuzz_d[j] = 1'b0;
      end else if (tick) begin
        tbuzz_d[j] = 1'b0;
        if (busy_q[j]) begin
          if (tm_sec_q[j] == 6'd0) begin
            tm_min_d[j] = tm_min_q[j] - 6'd1;
            tm_sec_d[j] = 6'd59;
          end else begin
            tm_sec_d[j] = tm_sec_q[j] - 6'd1;
          end
          if (tm_min_q[j] == 6'd0 && tm_sec_q[j] == 6'd1) begin
            busy_d[j] = 1'b0;
            tbuzz_d[j] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor mux; out-of-range index matches no channel and reads zero.
  always_comb begin
    timer_count_min_o = 6'd0;
    timer_count_sec_o = 6'd0;
    for (int j = 0; j < NUM_TIMERS; j++) begin
      if (mon_idx_i == TW'(j)) begin
        timer_count_min_o = tm_min_q[j];
        timer_count_sec_o = tm_sec_q[j];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      pulse_q <= 1'b0;
      {hour_q, min_q, sec_q} <= '0;
      day_q <= 5'd1;
      month_q <= 4'd1;
      year_q <= 12'd2020;
      al_hour_q <= '{default: '0};
      al_min_q <= '{default: '0};
      al_sec_q <= '{default: '0};
      ring_cnt_q <= '{default: '0};
      al_en_q <= '0;
      ring_q <= '0;
      tm_min_q <= '{default: '0};
      tm_sec_q <= '{default: '0};
      busy_q <= '0;
      tbuzz_q <= '0;
    end else begin
      presc_q <= presc_d;
      pulse_q <= pulse_d;
      {hour_q, min_q, sec_q, day_q, month_q, year_q} <=
          {hour_d, min_d, sec_d, day_d, month_d, year_d};
      al_hour_q <= al_hour_d;
      al_min_q <= al_min_d;
      al_sec_q <= al_sec_d;
      ring_cnt_q <= ring_cnt_d;
      al_en_q <= al_en_d;
      ring_q <= ring_d;
      tm_min_q <= tm_min_d;
      tm_sec_q <= tm_sec_d;
      busy_q <= busy_d;
      tbuzz_q <= tbuzz_d;
    end
  end

  assign {hour_o, min_o, sec_o, day_o, month_o, year_o} =
      {hour_q, min_q, sec_q, day_q, month_q, year_q};
  assign sec_pulse_o = pulse_q;
  assign alarm_buzzer_o = ring_q;
  assign timer_buzzer_o = tbuzz_q;
  assign timer_busy_o = busy_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench: calendar vectors from a table, then hand sequences for alarms,
// timers, a slow prescaler instance and asynchronous reset.
module tb_multi_alarm_clock;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        set_valid = 0, set_valid4 = 0;
  logic [4:0]  set_hour = 0, set_day = 0;
  logic [5:0]  set_min = 0, set_sec = 0;
  logic [3:0]  set_month = 0;
  logic [11:0] set_year = 0;
  logic        alarm_wr = 0, alarm_en = 0;
  logic [1:0]  alarm_idx = 0;
  logic [4:0]  alarm_hour = 0;
  logic [5:0]  alarm_min = 0, alarm_sec = 0;
  logic [3:0]  alarm_ack = 0;
  logic        timer_load = 0;
  logic [1:0]  timer_idx = 0, mon_idx = 0;
  logic [5:0]  timer_min = 0, timer_sec = 0;
  logic [2:0]  timer_cancel = 0;

  logic [4:0]  hour1, day1, hour4, day4;
  logic [5:0]  min1, sec1, min4, sec4, tcmin1, tcsec1, tcmin4, tcsec4;
  logic [3:0]  month1, month4, abuz1, abuz4;
  logic [11:0] year1, year4;
  logic        pulse1, pulse4;
  logic [2:0]  tbuz1, tbusy1;
  logic [1:0]  tbuz4, tbusy4;
  logic [37:0] now1, now4;
  assign now1 = {hour1, min1, sec1, day1, month1, year1};
  assign now4 = {hour4, min4, sec4, day4, month4, year4};

  // Idle inputs for the slow-prescaler instance.
  logic       z1 = 1'b0;
  logic [1:0] z2 = 2'b0;
  logic [0:0] zt = 1'b0;
  logic [4:0] z5 = 5'b0;
  logic [5:0] z6 = 6'b0;
  logic [3:0] z4 = 4'b0;

  multi_alarm_clock #(.TICK_DIV(1), .NUM_ALARMS(4), .NUM_TIMERS(3), .RING_SEC(10)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .set_valid_i(set_valid), .set_hour_i(set_hour),
    .set_min_i(set_min), .set_sec_i(set_sec), .set_day_i(set_day), .set_month_i(set_month),
    .set_year_i(set_year), .alarm_wr_i(alarm_wr), .alarm_idx_i(alarm_idx),
    .alarm_hour_i(alarm_hour), .alarm_min_i(alarm_min), .alarm_sec_i(alarm_sec),
    .alarm_en_i(alarm_en), .alarm_ack_i(alarm_ack), .timer_load_i(timer_load),
    .timer_idx_i(timer_idx), .timer_min_i(timer_min), .timer_sec_i(timer_sec),
    .timer_cancel_i(timer_cancel), .mon_idx_i(mon_idx), .timer_count_min_o(tcmin1),
    .timer_count_sec_o(tcsec1), .hour_o(hour1), .min_o(min1), .sec_o(sec1), .day_o(day1),
    .month_o(month1), .year_o(year1), .sec_pulse_o(pulse1), .alarm_buzzer_o(abuz1),
    .timer_buzzer_o(tbuz1), .timer_busy_o(tbusy1)
  );

  multi_alarm_clock #(.TICK_DIV(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .set_valid_i(set_valid4), .set_hour_i(set_hour),
    .set_min_i(set_min), .set_sec_i(set_sec), .set_day_i(set_day), .set_month_i(set_month),
    .set_year_i(set_year), .alarm_wr_i(z1), .alarm_idx_i(z2), .alarm_hour_i(z5),
    .alarm_min_i(z6), .alarm_sec_i(z6), .alarm_en_i(z1), .alarm_ack_i(z4),
    .timer_load_i(z1), .timer_idx_i(zt), .timer_min_i(z6), .timer_sec_i(z6),
    .timer_cancel_i(z2), .mon_idx_i(zt), .timer_count_min_o(tcmin4),
    .timer_count_sec_o(tcsec4), .hour_o(hour4), .min_o(min4), .sec_o(sec4), .day_o(day4),
    .month_o(month4), .year_o(year4), .sec_pulse_o(pulse4), .alarm_buzzer_o(abuz4),
    .timer_buzzer_o(tbuz4), .timer_busy_o(tbusy4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] tp(input int h, mi, s, d, mo, y);
    return {5'(h), 6'(mi), 6'(s), 5'(d), 4'(mo), 12'(y)};
  endfunction

  typedef struct {
    logic [4:0]  h;
    logic [5:0]  mi;
    logic [5:0]  s;
    logic [4:0]  d;
    logic [3:0]  mo;
    logic [11:0] y;
    int          n;
    logic [37:0] exp;
  } vec_t;

  function automatic vec_t mk(input int h, mi, s, d, mo, y, n, eh, emi, es, ed, emo, ey);
    vec_t v;
    v.h = 5'(h); v.mi = 6'(mi); v.s = 6'(s); v.d = 5'(d); v.mo = 4'(mo); v.y = 12'(y);
    v.n = n;
    v.exp = tp(eh, emi, es, ed, emo, ey);
    return v;
  endfunction

  task automatic set_time(input int h, mi, s, d, mo, y);
    set_hour = 5'(h); set_min = 6'(mi); set_sec = 6'(s);
    set_day = 5'(d); set_month = 4'(mo); set_year = 12'(y);
    set_valid = 1;
    tick();
    set_valid = 0;
  endtask

  task automatic wr_alarm(input int idx, h, mi, s);
    alarm_idx = 2'(idx); alarm_hour = 5'(h); alarm_min = 6'(mi); alarm_sec = 6'(s);
    alarm_en = 1; alarm_wr = 1;
    tick();
    alarm_wr = 0;
  endtask

  task automatic ld_timer(input int idx, mi, s);
    timer_idx = 2'(idx); timer_min = 6'(mi); timer_sec = 6'(s); timer_load = 1;
    tick();
    timer_load = 0;
  endtask

  vec_t vecs[17];
  logic [7:0] pat;
  logic [3:0] seen;
  bit found;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(23, 59, 58, 31, 12, 2023, 3,  0,  0,  1,  1,  1, 2024);
    vecs[1]  = mk(23, 59, 59, 28,  2, 2100, 1,  0,  0,  0,  1,  3, 2100);
    vecs[2]  = mk(23, 59, 59, 28,  2, 2000, 1,  0,  0,  0, 29,  2, 2000);
    vecs[3]  = mk(10,  0,  0, 30,  2, 2000, 0,  0,  0,  1, 29,  2, 2000);
    vecs[4]  = mk(23, 59, 59, 31, 12, 4095, 1,  0,  0,  0,  1,  1,    0);
    vecs[5]  = mk(23, 59, 59, 30,  4, 2021, 1,  0,  0,  0,  1,  5, 2021);
    vecs[6]  = mk(23, 59, 59, 28,  2, 2023, 1,  0,  0,  0,  1,  3, 2023);
    vecs[7]  = mk(12, 34, 56, 15,  6, 1999, 0, 12, 34, 56, 15,  6, 1999);
    vecs[8]  = mk(24,  0,  0,  1,  1, 2000, 0, 12, 34, 57, 15,  6, 1999);
    vecs[9]  = mk( 1,  0,  0,  1, 13, 2000, 0, 12, 34, 58, 15,  6, 1999);
    vecs[10] = mk( 1,  0,  0,  0,  1, 2000, 0, 12, 34, 59, 15,  6, 1999);
    vecs[11] = mk( 1, 60,  0,  1,  1, 2000, 0, 12, 35,  0, 15,  6, 1999);
    vecs[12] = mk(23, 59, 59, 29,  2, 2024, 1,  0,  0,  0,  1,  3, 2024);
    vecs[13] = mk( 0, 59, 59, 10, 10, 2010, 1,  1,  0,  0, 10, 10, 2010);
    vecs[14] = mk( 0,  0,  0, 31,  4, 2022, 0,  1,  0,  1, 10, 10, 2010);
    vecs[15] = mk(23, 59, 59, 31,  1, 2023, 2,  0,  0,  1,  1,  2, 2023);
    vecs[16] = mk(12,  0,  0,  1,  6, 2022, 0, 12,  0,  0,  1,  6, 2022);

    // Reset state, before any clock edge.
    #1 rst_n = 0;
    #2;
    check("reset_time", 64'(now1), 64'(tp(0, 0, 0, 1, 1, 2020)));
    check("reset_outs", {pulse1, abuz1, tbuz1, tbusy1, tcmin1, tcsec1}, '0);
    #9 rst_n = 1;
    tick();
    check("pulse_every_cycle", 64'(pulse1), 64'd1);

    // Slow prescaler: align on a pulse, then expect one every fourth cycle.
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (pulse4) found = 1;
      else tick();
    end
    check("pulse4_seen", 64'(found), 64'd1);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[i] = pulse4;
    end
    check("pulse4_pattern", 64'(pat), 64'h88);
    // Set on a pulse cycle: value held, next pulse four cycles later.
    set_hour = 7; set_min = 8; set_sec = 9; set_day = 10; set_month = 10; set_year = 2010;
    set_valid4 = 1;
    tick();
    set_valid4 = 0;
    pat = '0;
    for (int i = 0; i < 3; i++) begin
      pat[i] = pulse4;
      tick();
    end
    pat[3] = pulse4;
    check("pulse4_after_set", 64'(pat), 64'h8);
    check("time4_held", 64'(now4), 64'(tp(7, 8, 9, 10, 10, 2010)));
    tick();
    check("time4_adv", 64'(now4), 64'(tp(7, 8, 10, 10, 10, 2010)));

    // Calendar vectors.
    for (int v = 0; v < 17; v++) begin
      set_time(int'(vecs[v].h), int'(vecs[v].mi), int'(vecs[v].s), int'(vecs[v].d),
               int'(vecs[v].mo), int'(vecs[v].y));
      repeat (vecs[v].n) tick();
      check($sformatf("calendar_vec%0d", v), 64'(now1), 64'(vecs[v].exp));
    end

    // Two slots on the same second, ack one, let the other time out.
    wr_alarm(0, 0, 0, 5);
    wr_alarm(2, 0, 0, 5);
    set_time(0, 0, 0, 1, 1, 2021);
    check("set_no_fire", 64'(abuz1), 64'd0);
    repeat (4) tick();
    check("alarm_sec4", {sec1, abuz1}, {6'd4, 4'b0000});
    tick();
    check("alarm_sec5", {sec1, abuz1}, {6'd5, 4'b0101});
    repeat (2) tick();
    alarm_ack = 4'b0001;
    tick();
    alarm_ack = 4'b0000;
    check("alarm_ack0", {sec1, abuz1}, {6'd8, 4'b0100});
    repeat (6) tick();
    check("alarm_sec14", {sec1, abuz1}, {6'd14, 4'b0100});
    tick();
    check("alarm_timeout", {sec1, abuz1}, {6'd15, 4'b0000});
    set_time(23, 59, 58, 1, 1, 2021);
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= abuz1;
    end
    check("alarm_one_shot", {sec1, seen}, {6'd6, 4'b0000});

    // Timers.
    ld_timer(1, 1, 0);
    ld_timer(0, 0, 3);
    mon_idx = 1;
    #1;
    check("t1_first_dec", {tcmin1, tcsec1}, {6'd0, 6'd59});
    mon_idx = 0;
    #1;
    check("t0_loaded", {tbusy1, tcmin1, tcsec1}, {3'b011, 6'd0, 6'd3});
    repeat (2) tick();
    check("t0_pre_expire", {tbuz1, tbusy1}, {3'b000, 3'b011});
    tick();
    check("t0_expire", {tbuz1, tbusy1, tcmin1, tcsec1}, {3'b001, 3'b010, 12'd0});
    tick();
    check("t0_buzz_one_sec", 64'(tbuz1), 64'd0);
    timer_cancel = 3'b010;
    tick();
    timer_cancel = 3'b000;
    mon_idx = 1;
    #1;
    check("t1_cancel", {tbusy1, tcmin1, tcsec1}, {3'b000, 12'd0});
    ld_timer(0, 0, 0);
    check("t_zero_ignored", 64'(tbusy1), 64'd0);
    ld_timer(0, 0, 60);
    check("t_sec60_ignored", 64'(tbusy1), 64'd0);
    ld_timer(2, 0, 5);
    ld_timer(2, 0, 5);
    mon_idx = 2;
    #1;
    check("t2_reload_wins", {tbusy1, tcmin1, tcsec1}, {3'b100, 6'd0, 6'd5});
    timer_cancel = 3'b100;
    ld_timer(2, 0, 9);
    timer_cancel = 3'b000;
    check("t2_cancel_over_load", {tbusy1, tcmin1, tcsec1}, {3'b000, 12'd0});
    ld_timer(0, 0, 20);
    mon_idx = 3;
    #1;
    check("mon_out_of_range", {tcmin1, tcsec1}, 12'd0);
    mon_idx = 0;
    #1;
    check("mon_ch0", {tcmin1, tcsec1}, {6'd0, 6'd20});

    // Rewrite of a ringing slot silences it; bad alarm write is dropped.
    wr_alarm(1, 0, 0, 3);
    wr_alarm(3, 0, 0, 12);
    wr_alarm(3, 25, 0, 12);
    set_time(0, 0, 0, 1, 1, 2021);
    repeat (3) tick();
    check("slot1_fire", {sec1, abuz1}, {6'd3, 4'b0010});
    wr_alarm(1, 0, 0, 10);
    check("slot1_rewrite_silence", {sec1, abuz1}, {6'd4, 4'b0000});
    repeat (6) tick();
    check("slot1_refire", {sec1, abuz1}, {6'd10, 4'b0010});
    repeat (2) tick();
    check("slot3_bad_ignored", {sec1, abuz1}, {6'd12, 4'b1010});

    // Asynchronous reset mid-ring and mid-count.
    ld_timer(0, 5, 0);
    check("pre_reset_busy", {abuz1, tbusy1}, {4'b1010, 3'b001});
    #2 rst_n = 0;
    #1;
    check("async_reset_time", 64'(now1), 64'(tp(0, 0, 0, 1, 1, 2020)));
    check("async_reset_outs", {pulse1, abuz1, tbuz1, tbusy1, tcmin1, tcsec1}, '0);
    check("async_reset_dut4", {now4, pulse4, abuz4, tbusy4}, {tp(0, 0, 0, 1, 1, 2020), 7'd0});
    #3 rst_n = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
